ps2_kbd_rx: RTL and testbench

- PS/2 keyboard receiver that sits directly upstream of the VIA port A input.
- Deserialises device-clocked 11-bit PS/2 frames and presents each good scancode as a held byte on `data_out`, which is wired to VIA pa.
- `data_valid` is a level intended for the VIA CA1 interrupt input.
- The CPU's read of port A is returned as a single-cycle `data_ack`.

---
 rtl/ps2_pkg.sv | 19 +
 rtl/ps2_sync_filter.sv | 62 ++++++
 rtl/ps2_kbd_rx.sv | 180 ++++++++++++++++++
 tb/tb_ps2_kbd_rx.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard receiver.
//   state_t            : frame-level receive state
//   DATA_BITS          : data bits per PS/2 frame
//   TIMEOUT_CYCLES_DEF : default inter-edge timeout, in clk cycles
//   TIMEOUT_W          : counter width able to hold TIMEOUT_CYCLES_DEF
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    localparam int DATA_BITS          = 8;
    localparam int TIMEOUT_CYCLES_DEF = 2000;
    localparam int TIMEOUT_W          = $clog2(TIMEOUT_CYCLES_DEF + 1);

endpackage

// File: rtl/ps2_sync_filter.sv
// Conditions the raw PS/2 clock pin: a 2-FF synchroniser followed by a
// consistency filter. The filtered level only follows the synchronised input
// after FILTER_LEN consecutive samples that differ from it, so shorter pulses
// are ignored. A one-cycle pulse is produced when the filtered level falls.
//   clk  : system clock
//   rst  : asynchronous active-high reset (pipeline reset to idle-high)
//   din  : raw asynchronous input
//   fall : one-cycle pulse on a filtered 1->0 transition
module ps2_sync_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic fall
);

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic          meta_q, meta_d;
    logic          sync_q, sync_d;
    logic          filt_q, filt_d;
    logic          fall_q, fall_d;
    logic [CW-1:0] cnt_q,  cnt_d;

    always_comb begin
        meta_d = din;
        sync_d = meta_q;
        filt_d = filt_q;
        cnt_d  = '0;
        fall_d = 1'b0;
        // cnt_q counts consecutive samples disagreeing with the filtered
        // level; any agreeing sample restarts the count.
        if (sync_q != filt_q) begin
            if (cnt_q == CW'(FILTER_LEN - 1)) begin
                filt_d = sync_q;
                fall_d = ~sync_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            filt_q <= 1'b1;
            fall_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            filt_q <= filt_d;
            fall_q <= fall_d;
            cnt_q  <= cnt_d;
        end
    end

    assign fall = fall_q;

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver feeding a VIA port. Deserialises 11-bit frames
// (start, 8 data LSB first, odd parity, stop) clocked by the keyboard and
// holds each good scancode on data_out with data_valid raised until the CPU
// acknowledges it. Receive-only: the PS/2 pins are never driven.
//   clk, rst   : system clock, asynchronous active-high reset
//   ps2_clk    : raw PS/2 clock pin (asynchronous)
//   ps2_data   : raw PS/2 data pin (asynchronous)
//   data_out   : last accepted scancode (VIA pa)
//   data_valid : byte pending (VIA CA1)
//   data_ack   : one-cycle pulse, byte consumed
//   err_clr    : one-cycle pulse, clears sticky error flags
//   parity_err : sticky parity mismatch
//   frame_err  : sticky bad start, bad stop or timeout
//   overrun    : sticky good byte dropped while data_valid was high
module ps2_kbd_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] data_out,
    output logic       data_valid,
    input  logic       data_ack,
    input  logic       err_clr,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int BC_W = $clog2(DATA_BITS);

    logic fall;

    ps2_sync_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_clk_filter (
        .clk (clk),
        .rst (rst),
        .din (ps2_clk),
        .fall(fall)
    );

    logic                 dmeta_q, dmeta_d;
    logic                 dsync_q, dsync_d;
    state_t               state_q, state_d;
    logic [BC_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
    logic [DATA_BITS-1:0] sr_q, sr_d;
    logic                 par_q, par_d;
    logic [7:0]           data_out_q, data_out_d;
    logic                 data_valid_q, data_valid_d;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;
    logic                 fe_set, pe_set, ov_set, good;

    always_comb begin
        dmeta_d      = ps2_data;
        dsync_d      = dmeta_q;
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        to_cnt_d     = '0;
        sr_d         = sr_q;
        par_d        = par_q;
        data_out_d   = data_out_q;
        data_valid_d = data_valid_q;
        fe_set       = 1'b0;
        pe_set       = 1'b0;
        ov_set       = 1'b0;
        good         = 1'b0;

        if (state_q != IDLE) begin
            to_cnt_d = fall ? '0 : to_cnt_q + 1'b1;
        end

        // A stalled frame is abandoned before any further edge is considered.
        if (state_q != IDLE && to_cnt_q == TO_W'(TIMEOUT_CYCLES)) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            sr_d      = '0;
            to_cnt_d  = '0;
            fe_set    = 1'b1;
        end else if (fall) begin
            case (state_q)
                IDLE: begin
                    if (!dsync_q) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                        sr_d      = '0;
                    end else begin
                        fe_set = 1'b1;
                    end
                end
                DATA: begin
                    sr_d[bit_cnt_q] = dsync_q;
                    if (bit_cnt_q == BC_W'(DATA_BITS - 1)) begin
                        state_d   = PARITY;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
                PARITY: begin
                    par_d   = dsync_q;
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (!dsync_q) begin
                        fe_set = 1'b1;
                    end else if ((^sr_q ^ par_q) != 1'b1) begin
                        pe_set = 1'b1;
                    end else begin
                        good = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // An ack coinciding with delivery frees the slot for the new byte.
        if (good) begin
            if (!data_valid_q || data_ack) begin
                data_out_d   = sr_q;
                data_valid_d = 1'b1;
            end else begin
                ov_set = 1'b1;
            end
        end else if (data_ack) begin
            data_valid_d = 1'b0;
        end

        // Sticky flags: a new error in the clear cycle survives the clear.
        parity_err_d = (parity_err_q & ~err_clr) | pe_set;
        frame_err_d  = (frame_err_q  & ~err_clr) | fe_set;
        overrun_d    = (overrun_q    & ~err_clr) | ov_set;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dmeta_q      <= 1'b1;
            dsync_q      <= 1'b1;
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            to_cnt_q     <= '0;
            sr_q         <= '0;
            par_q        <= 1'b0;
            data_out_q   <= 8'h00;
            data_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            dmeta_q      <= dmeta_d;
            dsync_q      <= dsync_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            to_cnt_q     <= to_cnt_d;
            sr_q         <= sr_d;
            par_q        <= par_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Testbench for ps2_kbd_rx: table of frame records with fixed expectations,
// hand-written multi-cycle corner cases, then randomized frames against a
// frame-level behavioural model. clk is 400 kHz so a 40-cycle PS/2 bit
// period corresponds to a 10 kHz keyboard clock.
`timescale 1ns/1ps
module tb_ps2_kbd_rx;

    localparam int FILTER_LEN = 4;
    localparam int TIMEOUT    = 2000;
    localparam int H          = 20;   // PS/2 half period in clk cycles
    localparam int LAT        = FILTER_LEN + 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ack = 1'b0;
    logic       err_clr = 1'b0;
    logic       parity_err, frame_err, overrun;

    int n_checks = 0;
    int n_fail   = 0;

    ps2_kbd_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .data_out(data_out), .data_valid(data_valid), .data_ack(data_ack),
        .err_clr(err_clr), .parity_err(parity_err), .frame_err(frame_err),
        .overrun(overrun)
    );

    always #1250 clk = ~clk;

    initial begin
        #200_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0] b;
        logic       pf;     // corrupt parity
        logic       sb;     // corrupt stop bit
        logic       ack;    // ack pulse before the frame
        logic       clr;    // err_clr pulse before the frame
        logic [7:0] e_dout;
        logic       e_dv, e_pe, e_fe, e_ov;
    } vec_t;

    vec_t tbl [9];

    // frame-level reference model
    logic [7:0] m_dout;
    logic       m_dv, m_pe, m_fe, m_ov;

    task automatic model_frame(input logic [7:0] b, input logic pf, input logic sb);
        int ones;
        logic p;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += b[i];
        p = ((ones % 2) == 0) ? 1'b1 : 1'b0;
        p = p ^ pf;
        if (sb) m_fe = 1'b1;
        else if (((ones + p) % 2) != 1) m_pe = 1'b1;
        else if (!m_dv) begin m_dout = b; m_dv = 1'b1; end
        else m_ov = 1'b1;
    endtask

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [7:0] d, input logic dv,
                             input logic pe, input logic fe, input logic ov);
        check({tag, " data_out"}, data_out, d);
        check({tag, " data_valid"}, {7'd0, data_valid}, {7'd0, dv});
        check({tag, " parity_err"}, {7'd0, parity_err}, {7'd0, pe});
        check({tag, " frame_err"}, {7'd0, frame_err}, {7'd0, fe});
        check({tag, " overrun"}, {7'd0, overrun}, {7'd0, ov});
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_ack();
        data_ack = 1'b1; tick(1); data_ack = 1'b0;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1; tick(1); err_clr = 1'b0;
    endtask

    task automatic drive_bit(input logic v);
        ps2_data = v; tick(H); ps2_clk = 1'b0; tick(H); ps2_clk = 1'b1;
    endtask

    // Sends a whole frame and returns LAT cycles after the stop-bit fall with
    // ps2_clk still low. ack_at/clr_at give a cycle (0 = at the stop fall) at
    // which a one-cycle pulse is driven; dv_rise/fe_rise report the first
    // cycle where data_valid/frame_err were seen to rise.
    task automatic send_frame(input logic [7:0] b, input logic pf, input logic sb,
                              input int ack_at, input int clr_at, input int glitch_bit,
                              output int dv_rise, output int fe_rise);
        logic [10:0] bits;
        logic pdv, pfe;
        bits = {~sb, (~^b) ^ pf, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            ps2_data = bits[i];
            if (i == glitch_bit) begin
                tick(5); ps2_clk = 1'b0; tick(FILTER_LEN - 1); ps2_clk = 1'b1;
                tick(H - 4 - FILTER_LEN);
            end else begin
                tick(H);
            end
            ps2_clk = 1'b0;
            if (i < 10) begin tick(H); ps2_clk = 1'b1; end
        end
        dv_rise = -1; fe_rise = -1;
        pdv = data_valid; pfe = frame_err;
        data_ack = (ack_at == 0); err_clr = (clr_at == 0);
        for (int j = 1; j <= LAT; j++) begin
            @(negedge clk);
            data_ack = (j == ack_at); err_clr = (j == clr_at);
            if (data_valid && !pdv && dv_rise < 0) dv_rise = j;
            if (frame_err && !pfe && fe_rise < 0) fe_rise = j;
            pdv = data_valid; pfe = frame_err;
        end
        data_ack = 1'b0; err_clr = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input logic pf, input logic sb);
        int a, c;
        send_frame(b, pf, sb, -1, -1, -1, a, c);
    endtask

    task automatic end_frame();
        tick(H - LAT); ps2_clk = 1'b1; ps2_data = 1'b1; tick(2 * H);
    endtask

    initial begin
        int dvr, fer, l_dv, l_fe;
        logic [7:0] rb;
        logic ra, rc, rpf, rsb;

        tbl[0] = '{8'h1C, 0, 0, 0, 0, 8'h1C, 1, 0, 0, 0};
        tbl[1] = '{8'hF0, 0, 0, 1, 0, 8'hF0, 1, 0, 0, 0};
        tbl[2] = '{8'h1C, 1, 0, 1, 0, 8'hF0, 0, 1, 0, 0};
        tbl[3] = '{8'h12, 0, 0, 0, 1, 8'h12, 1, 0, 0, 0};
        tbl[4] = '{8'h34, 0, 0, 0, 0, 8'h12, 1, 0, 0, 1};
        tbl[5] = '{8'h55, 0, 0, 1, 1, 8'h55, 1, 0, 0, 0};
        tbl[6] = '{8'hAA, 0, 1, 0, 0, 8'h55, 1, 0, 1, 0};
        tbl[7] = '{8'h00, 0, 0, 1, 1, 8'h00, 1, 0, 0, 0};
        tbl[8] = '{8'hFF, 0, 0, 0, 0, 8'h00, 1, 0, 0, 1};

        // reset state
        tick(3);
        check_all("reset", 8'h00, 0, 0, 0, 0);
        rst = 1'b0;
        tick(2 * H);

        foreach (tbl[k]) begin
            if (tbl[k].clr) begin
                pulse_clr();
                check($sformatf("row%0d clr pe", k), {7'd0, parity_err}, 8'd0);
                check($sformatf("row%0d clr ov", k), {7'd0, overrun}, 8'd0);
            end
            if (tbl[k].ack) begin
                pulse_ack();
                check($sformatf("row%0d ack dv", k), {7'd0, data_valid}, 8'd0);
            end
            send(tbl[k].b, tbl[k].pf, tbl[k].sb);
            check_all($sformatf("row%0d", k), tbl[k].e_dout, tbl[k].e_dv,
                      tbl[k].e_pe, tbl[k].e_fe, tbl[k].e_ov);
            end_frame();
        end

        // ack coinciding with delivery
        pulse_clr();
        send_frame(8'h12, 0, 0, 0, -1, -1, l_dv, fer);
        check_all("ack_early 0x12", 8'h12, 1, 0, 0, 0);
        check("ack_early dv_rise_seen", {7'd0, l_dv > 0}, 8'd1);
        end_frame();
        send_frame(8'h56, 0, 0, l_dv - 1, -1, -1, dvr, fer);
        check_all("ack_same_cycle 0x56", 8'h56, 1, 0, 0, 0);
        end_frame();
        send(8'h78, 0, 0);
        check_all("overrun 0x78", 8'h56, 1, 0, 0, 1);
        end_frame();

        // set wins over simultaneous err_clr
        pulse_clr();
        send_frame(8'hAA, 0, 1, -1, -1, -1, dvr, l_fe);
        check("bad_stop fe", {7'd0, frame_err}, 8'd1);
        end_frame();
        pulse_clr();
        check("clr fe", {7'd0, frame_err}, 8'd0);
        send_frame(8'hAA, 0, 1, -1, l_fe - 1, -1, dvr, fer);
        check("set_wins fe", {7'd0, frame_err}, 8'd1);
        end_frame();
        pulse_clr();
        drive_bit(1'b1);   // bad start bit
        tick(10);
        check("bad_start fe", {7'd0, frame_err}, 8'd1);

        // timeout mid-frame, then recovery
        pulse_clr();
        pulse_ack();
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(i[0]);
        tick(TIMEOUT - H - 10);
        check("timeout early fe", {7'd0, frame_err}, 8'd0);
        tick(30);
        check("timeout fe", {7'd0, frame_err}, 8'd1);
        pulse_clr();
        send(8'h5A, 0, 0);
        check_all("after_timeout 0x5A", 8'h5A, 1, 0, 0, 0);
        end_frame();

        // glitch shorter than the filter
        pulse_ack();
        send_frame(8'h29, 0, 0, -1, -1, 4, dvr, fer);
        check_all("glitch 0x29", 8'h29, 1, 0, 0, 0);
        end_frame();

        // asynchronous reset mid-frame
        drive_bit(1'b1);
        tick(5);
        drive_bit(1'b0);
        for (int i = 0; i < 5; i++) drive_bit(1'b1);
        ps2_data = 1'b0;
        tick(5);
        #300 rst = 1'b1;
        #10 check_all("async_rst", 8'h00, 0, 0, 0, 0);
        tick(3);
        rst = 1'b0;
        ps2_data = 1'b1;
        tick(2 * H);
        send(8'hE1, 0, 0);
        check_all("after_rst 0xE1", 8'hE1, 1, 0, 0, 0);
        end_frame();

        // randomized frames against the model
        m_dout = 8'hE1; m_dv = 1'b1; m_pe = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
        for (int r = 0; r < 40; r++) begin
            ra  = ($urandom_range(0, 1) == 1);
            rc  = ($urandom_range(0, 3) == 0);
            rpf = ($urandom_range(0, 7) == 0);
            rsb = ($urandom_range(0, 7) == 0);
            rb  = 8'($urandom_range(0, 255));
            if (rc) begin pulse_clr(); m_pe = 0; m_fe = 0; m_ov = 0; end
            if (ra) begin pulse_ack(); m_dv = 1'b0; end
            send(rb, rpf, rsb);
            model_frame(rb, rpf, rsb);
            check_all($sformatf("rand%0d b=%0h", r, rb), m_dout, m_dv, m_pe, m_fe, m_ov);
            end_frame();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
